hankel_stream_gen: RTL and testbench

// Generalised Hankel/Toeplitz matrix generator. The block fetches the ROW+COL-1 samples it needs from a

---
 rtl/hankel_stream_gen_if.sv | 31 +++
 rtl/hankel_stream_gen.sv | 125 ++++++++++++
 tb/tb_hankel_stream_gen.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/hankel_stream_gen_if.sv
// Bundle between the Hankel/Toeplitz generator, its sample RAM and the matrix consumer.
// master = generator side, slave = environment (requester, memory, downstream sink).
interface hankel_stream_gen_if #(
  parameter int WIDTH = 16,
  parameter int ADDR  = 8,
  parameter int IDXW  = 8
);
  logic             start;
  logic             mode;
  logic [ADDR-1:0]  base_addr;
  logic             rd;
  logic [ADDR-1:0]  addr;
  logic [WIDTH-1:0] data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [IDXW-1:0]  m_row;
  logic [IDXW-1:0]  m_col;
  logic             m_last;
  logic             busy;
  logic             done;

  modport master (
    input  start, mode, base_addr, data, m_ready,
    output rd, addr, m_valid, m_data, m_row, m_col, m_last, busy, done
  );
  modport slave (
    output start, mode, base_addr, data, m_ready,
    input  rd, addr, m_valid, m_data, m_row, m_col, m_last, busy, done
  );
endinterface

// File: rtl/hankel_stream_gen.sv
// Fetches ROW+COL-1 samples into a local buffer, then streams the Hankel or Toeplitz
// matrix row-major on a valid/ready port.
module hankel_stream_gen #(
  parameter int ROW   = 4,
  parameter int COL   = 4,
  parameter int WIDTH = 16,
  parameter int ADDR  = 8,
  parameter int IDXW  = 8
) (
  input  logic clk,
  input  logic rst_n,
  hankel_stream_gen_if.master bus
);
  localparam int N  = ROW + COL - 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;
  state_t state, nxt;

  logic             mode_q;
  logic [CW-1:0]    fidx;
  logic             cap_vld;
  logic [CW-1:0]    cap_idx;
  logic [WIDTH-1:0] sbuf [2**CW];
  logic [IDXW-1:0]  nr, nc;
  logic [CW-1:0]    ei;
  logic [WIDTH-1:0] ev;
  logic             nlast, hs, load_first;

  assign hs         = bus.m_valid & bus.m_ready;
  assign load_first = (state == FETCH) && cap_vld && (cap_idx == CW'(N-1));

  function automatic logic [CW-1:0] eidx(input logic [IDXW-1:0] r, input logic [IDXW-1:0] c,
                                         input logic md);
    int v;
    v = md ? (int'(r) - int'(c) + COL - 1) : (int'(r) + int'(c));
    return CW'(v);
  endfunction

  // Next element coordinates and value; the bypass covers the sample captured this very edge
  // (e.g. ROW=1 Toeplitz starts on the last fetched sample).
  always_comb begin
    nr = bus.m_row;
    nc = bus.m_col;
    if (load_first) begin
      nr = '0;
      nc = '0;
    end else if (bus.m_col == IDXW'(COL-1)) begin
      nc = '0;
      nr = bus.m_row + 1'b1;
    end else begin
      nc = bus.m_col + 1'b1;
    end
    nlast = (nr == IDXW'(ROW-1)) && (nc == IDXW'(COL-1));
    ei    = eidx(nr, nc, mode_q);
    ev    = (cap_vld && cap_idx == ei) ? bus.data : sbuf[ei];
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (bus.start) nxt = FETCH;
      FETCH: if (load_first) nxt = EMIT;
      EMIT:  if (hs && bus.m_last) nxt = DONE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= 1'b0;
      fidx        <= '0;
      cap_vld     <= 1'b0;
      cap_idx     <= '0;
      bus.rd      <= 1'b0;
      bus.addr    <= '0;
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      bus.m_row   <= '0;
      bus.m_col   <= '0;
      bus.m_last  <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      bus.busy <= (nxt != IDLE);
      bus.done <= (nxt == DONE);
      // Read data returns one cycle after rd, so the capture slot trails the read by one.
      cap_vld  <= bus.rd;
      cap_idx  <= fidx;
      if (state == IDLE && bus.start) begin
        mode_q   <= bus.mode;
        bus.addr <= bus.base_addr;
        bus.rd   <= 1'b1;
        fidx     <= '0;
      end else if (bus.rd) begin
        if (fidx == CW'(N-1)) begin
          bus.rd <= 1'b0;
        end else begin
          fidx     <= fidx + 1'b1;
          bus.addr <= bus.addr + 1'b1;
        end
      end
      if (load_first || (state == EMIT && hs && !bus.m_last)) begin
        bus.m_valid <= 1'b1;
        bus.m_data  <= ev;
        bus.m_row   <= nr;
        bus.m_col   <= nc;
        bus.m_last  <= nlast;
      end else if (state == EMIT && hs) begin
        bus.m_valid <= 1'b0;
        bus.m_last  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cap_vld) sbuf[cap_idx] <= bus.data;
  end
endmodule

// File: tb/tb_hankel_stream_gen.sv
// Directed bench: two generator instances (4x4 and 2x5) with behavioural sample RAMs.
module tb_hankel_stream_gen;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hankel_stream_gen_if #(.WIDTH(16), .ADDR(8), .IDXW(8)) ia ();
  hankel_stream_gen_if #(.WIDTH(16), .ADDR(8), .IDXW(8)) ib ();

  hankel_stream_gen #(.ROW(4), .COL(4), .WIDTH(16), .ADDR(8), .IDXW(8)) ua (
    .clk(clk), .rst_n(rst_n), .bus(ia.master));
  hankel_stream_gen #(.ROW(2), .COL(5), .WIDTH(16), .ADDR(8), .IDXW(8)) ub (
    .clk(clk), .rst_n(rst_n), .bus(ib.master));

  logic        start_a, start_b, mode, m_ready, sel_b;
  logic [7:0]  base_addr;
  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];
  int total = 0;
  int bad   = 0;

  assign ia.start = start_a;  assign ib.start = start_b;
  assign ia.mode  = mode;     assign ib.mode  = mode;
  assign ia.base_addr = base_addr;  assign ib.base_addr = base_addr;
  assign ia.m_ready = m_ready;      assign ib.m_ready = m_ready;

  always @(posedge clk) if (ia.rd) ia.data <= mem_a[ia.addr];
  always @(posedge clk) if (ib.rd) ib.data <= mem_b[ib.addr];

  logic        o_rd, o_valid, o_last, o_busy, o_done;
  logic [7:0]  o_addr, o_row, o_col;
  logic [15:0] o_data;
  assign o_rd    = sel_b ? ib.rd      : ia.rd;
  assign o_addr  = sel_b ? ib.addr    : ia.addr;
  assign o_valid = sel_b ? ib.m_valid : ia.m_valid;
  assign o_data  = sel_b ? ib.m_data  : ia.m_data;
  assign o_row   = sel_b ? ib.m_row   : ia.m_row;
  assign o_col   = sel_b ? ib.m_col   : ia.m_col;
  assign o_last  = sel_b ? ib.m_last  : ia.m_last;
  assign o_busy  = sel_b ? ib.busy    : ia.busy;
  assign o_done  = sel_b ? ib.done    : ia.done;

  logic [15:0] ex1 [16] = '{16'h1, 16'h2, 16'h3, 16'h4, 16'h2, 16'h3, 16'h4, 16'h5,
                            16'h3, 16'h4, 16'h5, 16'h6, 16'h4, 16'h5, 16'h6, 16'h7};
  logic [15:0] ex2 [16] = '{16'h4, 16'h3, 16'h2, 16'h1, 16'h5, 16'h4, 16'h3, 16'h2,
                            16'h6, 16'h5, 16'h4, 16'h3, 16'h7, 16'h6, 16'h5, 16'h4};
  logic [15:0] ex4 [16] = '{16'hFF, 16'h100, 16'h1, 16'h2, 16'h100, 16'h1, 16'h2, 16'h3,
                            16'h1, 16'h2, 16'h3, 16'h4, 16'h2, 16'h3, 16'h4, 16'h5};
  logic [15:0] ex6 [16] = '{16'h0, 16'h1, 16'h2, 16'h3, 16'h4, 16'h1, 16'h2, 16'h3,
                            16'h4, 16'h5, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full matrix: checks read strobes/addresses, latency, stream content, hold, done/busy.
  task automatic run(input bit sel, input bit md, input logic [7:0] base, input bit bp,
                     input int R, input int C, input logic [15:0] ex [16]);
    int n, nn, e, beats, reads, first_v, done_e, last_hs;
    bit hold;
    logic [15:0] pd;
    logic [7:0]  pr, pc, ea;
    n = R * C; nn = R + C - 1; e = 0; beats = 0; reads = 0;
    first_v = -1; done_e = -1; last_hs = -2; hold = 0; pd = '0; pr = '0; pc = '0;
    sel_b = sel; mode = md; base_addr = base;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    chk("busy_after_start", 32'(o_busy), 32'd1);
    while (e < 200 && !(done_e >= 0 && e > done_e)) begin
      m_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      #3;
      chk("rd_window", 32'(o_rd), 32'(e < nn));
      if (o_rd) begin
        ea = base + 8'(reads);
        chk("rd_addr", 32'(o_addr), 32'(ea));
        reads++;
      end
      if (o_valid && first_v < 0) first_v = e;
      if (hold) begin
        chk("hold_valid", 32'(o_valid), 32'd1);
        chk("hold_data", 32'(o_data), 32'(pd));
        chk("hold_row", 32'(o_row), 32'(pr));
        chk("hold_col", 32'(o_col), 32'(pc));
      end
      if (o_valid && m_ready && beats < 16) begin
        chk("beat_data", 32'(o_data), 32'(ex[beats]));
        chk("beat_row", 32'(o_row), 32'(beats / C));
        chk("beat_col", 32'(o_col), 32'(beats % C));
        chk("beat_last", 32'(o_last), 32'(beats == n - 1));
        if (o_last) last_hs = e;
        beats++;
      end
      hold = o_valid && !m_ready;
      pd = o_data; pr = o_row; pc = o_col;
      if (o_done && done_e < 0) begin
        done_e = e;
        chk("busy_in_done", 32'(o_busy), 32'd1);
      end
      @(posedge clk); #1;
      e++;
    end
    chk("first_valid_edge", 32'(first_v), 32'(nn + 1));
    chk("beat_count", 32'(beats), 32'(n));
    chk("read_count", 32'(reads), 32'(nn));
    chk("done_after_last", 32'(done_e), 32'(last_hs + 1));
    chk("done_one_cycle", 32'(o_done), 32'd0);
    chk("idle_not_busy", 32'(o_busy), 32'd0);
    m_ready = 1'b0;
  endtask

  initial begin
    int w;
    for (int k = 0; k < 256; k++) begin
      mem_a[k] = 16'(k + 1);
      mem_b[k] = 16'(k);
    end
    rst_n = 1'b0; start_a = 0; start_b = 0; mode = 0; m_ready = 0; sel_b = 0; base_addr = '0;
    #3;
    chk("rst_rd", 32'(ia.rd), 0);          chk("rst_addr", 32'(ia.addr), 0);
    chk("rst_valid", 32'(ia.m_valid), 0);  chk("rst_data", 32'(ia.m_data), 0);
    chk("rst_last", 32'(ia.m_last), 0);    chk("rst_busy", 32'(ia.busy), 0);
    chk("rst_done", 32'(ia.done), 0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    run(0, 0, 8'h00, 0, 4, 4, ex1);   // Hankel, no backpressure
    run(0, 1, 8'h00, 0, 4, 4, ex2);   // Toeplitz
    run(0, 0, 8'h00, 1, 4, 4, ex1);   // Hankel under random backpressure
    run(0, 0, 8'hFE, 0, 4, 4, ex4);   // address wrap
    run(1, 0, 8'h00, 0, 2, 5, ex6);   // 2x5 instance

    // start ignored during FETCH and EMIT, then async reset mid-stream
    sel_b = 0; mode = 0; base_addr = 8'h00; m_ready = 1'b1;
    start_a = 1'b1; @(posedge clk); #1; start_a = 1'b0;
    repeat (2) @(posedge clk); #1;
    start_a = 1'b1; @(posedge clk); #1; start_a = 1'b0;
    chk("fetch_ignore_addr3", 32'(o_addr), 32'd3);
    @(posedge clk); #1;
    chk("fetch_ignore_addr4", 32'(o_addr), 32'd4);
    chk("fetch_ignore_rd", 32'(o_rd), 32'd1);
    m_ready = 1'b0;
    w = 0;
    while (!o_valid && w < 20) begin @(posedge clk); #1; w++; end
    chk("emit_reached", 32'(o_valid), 32'd1);
    m_ready = 1'b1;
    repeat (5) @(posedge clk); #1;
    m_ready = 1'b0;
    start_a = 1'b1;
    repeat (2) @(posedge clk); #1;
    start_a = 1'b0;
    chk("emit_ignore_data", 32'(o_data), 32'h3);
    chk("emit_ignore_row", 32'(o_row), 32'd1);
    chk("emit_ignore_col", 32'(o_col), 32'd1);
    chk("emit_ignore_busy", 32'(o_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(o_valid), 0);  chk("arst_data", 32'(o_data), 0);
    chk("arst_row", 32'(o_row), 0);      chk("arst_col", 32'(o_col), 0);
    chk("arst_addr", 32'(o_addr), 0);    chk("arst_busy", 32'(o_busy), 0);
    chk("arst_done", 32'(o_done), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run(0, 0, 8'h00, 0, 4, 4, ex1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
